// File: rtl/twoscomplement_signmagnitude_pkg.sv
// Shared constants for the two's-complement to sign-magnitude converter.
// The special bit patterns are derived from the word width so every instance agrees on them.
package twoscomplement_signmagnitude_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  // 1 followed by width-1 zeros: the only input whose magnitude does not fit.
  function automatic logic [MAX_WIDTH-1:0] most_negative(input int width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

  // All ones across width-1 bits: the largest representable magnitude.
  function automatic logic [MAX_WIDTH-1:0] max_magnitude(input int width);
    return most_negative(width) - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/twoscomplement_signmagnitude_tc_abs.sv
// Combinational absolute value of a two's-complement word.
// The most-negative input has no positive counterpart, so it saturates and flags overflow.
module tc_abs
  import twoscomplement_signmagnitude_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-2:0] mag,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_negative(WIDTH));
  localparam logic [WIDTH-2:0] MAX_MAG  = (WIDTH-1)'(max_magnitude(WIDTH));

  // The low bits of (~a + 1) depend only on the low bits of a.
  logic [WIDTH-2:0] negated_low;

  always_comb begin
    negated_low = ~a[WIDTH-2:0] + (WIDTH-1)'(1);
    ovf         = (a == MOST_NEG);
    if (ovf) begin
      mag = MAX_MAG;
    end else if (a[WIDTH-1]) begin
      mag = negated_low;
    end else begin
      mag = a[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/twoscomplement_signmagnitude.sv
// Registered two's-complement to sign-magnitude converter, one result per cycle, one cycle latency.
// Outputs come straight from flops; data holds between valid samples.
module twoscomplement_signmagnitude
  import twoscomplement_signmagnitude_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic             sign,
  output logic [WIDTH-2:0] mag,
  output logic             ovf
);

  logic [WIDTH-2:0] abs_mag;
  logic             abs_ovf;

  logic             valid_reg;
  logic             sign_reg;
  logic [WIDTH-2:0] mag_reg;
  logic             ovf_reg;

  tc_abs #(
    .WIDTH(WIDTH)
  ) u_abs (
    .a  (a),
    .mag(abs_mag),
    .ovf(abs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      sign_reg  <= 1'b0;
      mag_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sign_reg <= a[WIDTH-1];
        mag_reg  <= abs_mag;
        ovf_reg  <= abs_ovf;
      end
    end
  end

  assign out_valid = valid_reg;
  assign sign      = sign_reg;
  assign mag       = mag_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_twoscomplement_signmagnitude.sv
// Bench for the sign-magnitude converter: directed, exhaustive and random steps on an 8-bit
// and a 4-bit instance, checked every cycle against an integer-arithmetic reference.
module tb_twoscomplement_signmagnitude;

  logic       clk;
  logic       rst;
  logic       in_valid8;
  logic [7:0] a8;
  logic       out_valid8;
  logic       sign8;
  logic [6:0] mag8;
  logic       ovf8;
  logic       in_valid4;
  logic [3:0] a4;
  logic       out_valid4;
  logic       sign4;
  logic [2:0] mag4;
  logic       ovf4;

  int passed = 0;
  int total  = 0;

  // Expected output state per instance ({ovf, sign, mag} packed as an integer).
  logic [31:0] held8;
  logic [31:0] held4;
  logic        ev8;
  logic        ev4;

  twoscomplement_signmagnitude #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .a        (a8),
    .out_valid(out_valid8),
    .sign     (sign8),
    .mag      (mag8),
    .ovf      (ovf8)
  );

  twoscomplement_signmagnitude #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid4),
    .a        (a4),
    .out_valid(out_valid4),
    .sign     (sign4),
    .mag      (mag4),
    .ovf      (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interpret the pattern as a signed integer and take its absolute value.
  function automatic logic [31:0] model(input int w, input int pattern);
    int half;
    int value;
    int result;
    half  = 1 << (w - 1);
    value = (pattern >= half) ? pattern - 2 * half : pattern;
    if (value == -half) begin
      result = (1 << w) | (1 << (w - 1)) | (half - 1);
    end else if (value < 0) begin
      result = (1 << (w - 1)) | (-value);
    end else begin
      result = value;
    end
    return 32'(result);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic r,
                      input logic v8, input logic [7:0] x8,
                      input logic v4, input logic [3:0] x4);
    rst       = r;
    in_valid8 = v8;
    a8        = x8;
    in_valid4 = v4;
    a4        = x4;
    @(posedge clk);
    #1;
    if (r) begin
      ev8   = 1'b0;
      ev4   = 1'b0;
      held8 = '0;
      held4 = '0;
    end else begin
      ev8 = v8;
      ev4 = v4;
      if (v8) held8 = model(8, int'(x8));
      if (v4) held4 = model(4, int'(x4));
    end
    $display("%s: rst=%0b w8 v=%0b a=%02h -> v=%0b s=%0b m=%02h o=%0b | w4 v=%0b a=%01h -> v=%0b s=%0b m=%0h o=%0b",
             tag, r, v8, x8, out_valid8, sign8, mag8, ovf8, v4, x4, out_valid4, sign4, mag4, ovf4);
    check({tag, "_valid8"}, 32'(out_valid8), 32'(ev8));
    check({tag, "_data8"}, 32'({ovf8, sign8, mag8}), held8);
    check({tag, "_valid4"}, 32'(out_valid4), 32'(ev4));
    check({tag, "_data4"}, 32'({ovf4, sign4, mag4}), held4);
  endtask

  logic [7:0] dir_vals [6];

  initial begin
    rst = 1'b1; in_valid8 = 1'b0; a8 = '0; in_valid4 = 1'b0; a4 = '0;
    held8 = '0; held4 = '0; ev8 = 1'b0; ev4 = 1'b0;

    // Reset wins over a valid sample in the same cycle.
    step("reset", 1'b1, 1'b1, 8'h05, 1'b1, 4'h5);
    step("reset_hold", 1'b1, 1'b1, 8'h80, 1'b1, 4'h8);
    // First sample in the cycle reset drops is accepted.
    step("first_after_reset", 1'b0, 1'b1, 8'h05, 1'b1, 4'h3);

    // Six back-to-back samples covering the called-out patterns.
    dir_vals = '{8'hFB, 8'hF6, 8'h81, 8'h7F, 8'h80, 8'h00};
    for (int i = 0; i < 6; i++) begin
      step("stream", 1'b0, 1'b1, dir_vals[i], 1'b1, 4'(i + 6));
    end
    step("idle_hold", 1'b0, 1'b0, 8'h33, 1'b0, 4'h1);
    step("idle_hold", 1'b0, 1'b0, 8'hC4, 1'b0, 4'h9);

    // A sample taken just before reset must not leak out afterwards.
    step("pre_reset_sample", 1'b0, 1'b1, 8'h9C, 1'b1, 4'hC);
    step("reset_mid", 1'b1, 1'b1, 8'h42, 1'b1, 4'h2);
    step("after_reset_idle", 1'b0, 1'b0, 8'h42, 1'b0, 4'h2);

    for (int i = 0; i < 256; i++) begin
      step("sweep8", 1'b0, 1'b1, 8'(i), 1'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      step("sweep4", 1'b0, 1'($urandom), 8'($urandom), 1'b1, 4'(i));
    end
    for (int i = 0; i < 200; i++) begin
      step("random", 1'($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/twoscomplement_signmagnitude.md
TWOSCOMPLEMENT_SIGNMAGNITUDE -- requirements
Module: twoscomplement_signmagnitude

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the input word width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a is sampled this cycle.
REQ-005 The block SHALL have port a, input, WIDTH bits, the two's-complement signed operand.
REQ-006 The block SHALL have port out_valid, output, 1 bit, meaning sign/mag/ovf hold a new result.
REQ-007 The block SHALL have port sign, output, 1 bit, the sign-magnitude sign bit (1 = negative).
REQ-008 The block SHALL have port mag, output, WIDTH-1 bits, the unsigned magnitude.
REQ-009 The block SHALL have port ovf, output, 1 bit, meaning the magnitude is not representable and was saturated.

Function
REQ-010 On a rising clk with in_valid=1 and rst=0, the block SHALL register sign = a[WIDTH-1].
REQ-011 For a[WIDTH-1]=0, the registered mag SHALL be a[WIDTH-2:0].
REQ-012 For a[WIDTH-1]=1, the registered mag SHALL be the low WIDTH-1 bits of (~a + 1).
REQ-013 Latency SHALL be exactly 1 cycle: out_valid is high the cycle after in_valid was sampled high, otherwise low.
REQ-014 Back-to-back in_valid SHALL be accepted every cycle with no stall and no backpressure.
REQ-015 With in_valid=0, sign, mag and ovf SHALL hold their last values while out_valid=0.
REQ-016 For the most-negative input (a = 1 followed by WIDTH-1 zeros), the block SHALL output sign=1, mag = all ones (saturated, 127 for WIDTH=8) and ovf=1.
REQ-017 For every other input, ovf SHALL be 0.
REQ-018 Input zero SHALL produce sign=0, mag=0; negative zero SHALL never be produced.
REQ-019 The most-positive input SHALL produce sign=0, mag all ones, ovf=0 (01111111 -> 0/1111111).
REQ-020 Outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-021 While rst=1 at a rising clk, the block SHALL clear out_valid, sign, mag and ovf to 0.
REQ-022 Reset SHALL take priority over in_valid in the same cycle.
REQ-023 A sample accepted in the cycle before reset asserts SHALL be discarded, so no out_valid pulse follows reset.
REQ-024 The first sample with in_valid=1 in the cycle rst deasserts SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the default WIDTH constant and a function or constant for the most-negative and max-magnitude patterns, derived from WIDTH.
REQ-026 One combinational sub-module, tc_abs, SHALL compute the magnitude and overflow from a.
REQ-027 The top level SHALL contain only the output register stage and valid pipeline.

Verification
REQ-028 WIDTH=8, a=00000101, in_valid=1 -> next cycle out_valid=1, sign=0, mag=0000101, ovf=0.
REQ-029 WIDTH=8: a=11111011 -> sign=1, mag=0000101; a=11110110 -> sign=1, mag=0001010; ovf=0 for both.
REQ-030 WIDTH=8: a=10000001 -> sign=1, mag=1111111, ovf=0; a=01111111 -> sign=0, mag=1111111, ovf=0.
REQ-031 WIDTH=8: a=10000000 -> sign=1, mag=1111111, ovf=1; a=00000000 -> sign=0, mag=0, ovf=0.
REQ-032 Streaming 6 consecutive valid samples -> 6 consecutive out_valid cycles in order; then in_valid=0 -> out_valid=0 with data held.
REQ-033 rst asserted with in_valid=1 -> next cycle all outputs 0, and no out_valid pulse after rst drops.
REQ-034 Exhaustive sweep of all 256 inputs (WIDTH=8) against a reference model, plus a smoke test at WIDTH=4.
